// File: rtl/csa_accum_pkg.sv
// Shared types and sizing helpers for the carry-save accumulator sequencer.
package csa_accum_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } state_e;

  // Number of CHUNK-wide slices needed to cover an ACC_W-wide value.
  function automatic int nch(input int acc_w, input int chunk);
    return (acc_w + chunk - 1) / chunk;
  endfunction

  localparam int NCH    = nch(24, 8);
  localparam int CIDX_W = (NCH > 1) ? $clog2(NCH) : 1;

endpackage

// File: rtl/csa_3to2_gen.sv
// Bitwise 3:2 compressor: sum and majority (unshifted carry) per bit.
module csa_3to2_gen #(
  parameter int W = 24
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] c_i,
  output logic [W-1:0] sum_o,
  output logic [W-1:0] cout_o
);

  assign sum_o  = a_i ^ b_i ^ c_i;
  assign cout_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/csa_accum_seq.sv
// Multi-operand accumulator: redundant (S, C) running total, chunked
// carry-propagate resolve on the last beat, valid/ready result port.
module csa_accum_seq
  import csa_accum_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int ACC_W = 24,
  parameter int CHUNK = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_cnt
);

  localparam int NCH_L    = nch(ACC_W, CHUNK);
  localparam int PAD_W    = NCH_L * CHUNK;
  localparam int CIDX_W_L = (NCH_L > 1) ? $clog2(NCH_L) : 1;
  localparam int BASE_W   = (PAD_W > 1) ? $clog2(PAD_W) : 1;
  localparam logic [CIDX_W_L-1:0] LAST_IDX = CIDX_W_L'(NCH_L - 1);
  localparam logic [CNT_W-1:0]    CNT_MAX  = {CNT_W{1'b1}};

  state_e                state_q;
  logic [ACC_W-1:0]      s_q;
  logic [ACC_W-1:0]      c_q;
  logic [PAD_W-1:0]      r_q;
  logic [CIDX_W_L-1:0]   cidx_q;
  logic                  carry_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  out_valid_q;

  logic [ACC_W-1:0]      x_s;
  logic [ACC_W-1:0]      csa_sum_s;
  logic [ACC_W-1:0]      csa_maj_s;
  logic                  accept_s;
  logic [PAD_W-1:0]      s_pad_s;
  logic [PAD_W-1:0]      c_pad_s;
  logic [BASE_W-1:0]     base_s;
  logic [CHUNK:0]        chunk_sum_s;

  assign x_s = ACC_W'(in_data);

  csa_3to2_gen #(.W(ACC_W)) u_csa (
    .a_i    (s_q),
    .b_i    (c_q),
    .c_i    (x_s),
    .sum_o  (csa_sum_s),
    .cout_o (csa_maj_s)
  );

  // clr and reset must block a same-cycle beat, so readiness is gated by them directly.
  assign in_ready = rst_n & ~clr & ((state_q == IDLE) | (state_q == ACCUM));
  assign accept_s = in_valid & in_ready;

  assign s_pad_s     = PAD_W'(s_q);
  assign c_pad_s     = PAD_W'(c_q);
  assign base_s      = BASE_W'(cidx_q) * BASE_W'(CHUNK);
  assign chunk_sum_s = {1'b0, s_pad_s[base_s +: CHUNK]} + {1'b0, c_pad_s[base_s +: CHUNK]}
                     + {{CHUNK{1'b0}}, carry_q};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      s_q         <= '0;
      c_q         <= '0;
      r_q         <= '0;
      cidx_q      <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else if (clr) begin
      state_q     <= IDLE;
      s_q         <= '0;
      c_q         <= '0;
      cidx_q      <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            s_q     <= x_s;
            c_q     <= '0;
            cnt_q   <= CNT_W'(1);
            cidx_q  <= '0;
            carry_q <= 1'b0;
            state_q <= in_last ? RESOLVE : ACCUM;
          end
        end
        ACCUM: begin
          if (accept_s) begin
            s_q     <= csa_sum_s;
            c_q     <= {csa_maj_s[ACC_W-2:0], 1'b0};
            cnt_q   <= (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
            state_q <= in_last ? RESOLVE : ACCUM;
          end
        end
        RESOLVE: begin
          // Carry out of the top chunk is dropped: the total is modulo 2^ACC_W.
          r_q[base_s +: CHUNK] <= chunk_sum_s[CHUNK-1:0];
          if (cidx_q == LAST_IDX) begin
            cidx_q      <= '0;
            carry_q     <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            cidx_q  <= cidx_q + CIDX_W_L'(1);
            carry_q <= chunk_sum_s[CHUNK];
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            s_q         <= '0;
            c_q         <= '0;
            cnt_q       <= '0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = r_q[ACC_W-1:0];
  assign out_cnt   = cnt_q;

endmodule
